reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 67 ++++++
 tb/tb_reg_dump_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: streams registers FIRST_REG..LAST_REG as valid/ready beats; define REG_DUMP_CHECKSUM_EN to add the csum XOR output
module reg_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic [4:0]  rdAddr,
  input  logic [63:0] rdData,
  output logic [63:0] outData,
  output logic [4:0]  outIndex,
  output logic        outValid,
  input  logic        outReady,
  output logic        busy,
  output logic        done
`ifdef REG_DUMP_CHECKSUM_EN
  ,
  output logic [63:0] csum
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d, out_index_q, out_index_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d, done_q, done_d, go, xfer, last;
  always_comb begin
    go          = state_q == IDLE && start;
    xfer        = state_q == SEND && out_valid_q && outReady;
    last        = idx_q == 5'(LAST_REG);
    state_d     = go ? LOAD : state_q == LOAD ? SEND : xfer ? (last ? IDLE : LOAD) : state_q;
    idx_d       = go ? 5'(FIRST_REG) : (xfer && !last) ? idx_q + 5'd1 : idx_q;
    out_data_d  = state_q == LOAD ? rdData : out_data_q;
    out_index_d = state_q == LOAD ? idx_q : out_index_q;
    out_valid_d = state_q == LOAD ? 1'b1 : xfer ? 1'b0 : out_valid_q;
    done_d      = xfer && last;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= 5'(FIRST_REG);
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end
`ifdef REG_DUMP_CHECKSUM_EN
  logic [63:0] csum_q, csum_d;
  always_comb csum_d = go ? '0 : xfer ? csum_q ^ out_data_q : csum_q;
  always_ff @(posedge CLK) csum_q <= RST ? '0 : csum_d;
  assign csum = csum_q;
`endif
  assign rdAddr   = idx_q;
  assign outData  = out_data_q;
  assign outIndex = out_index_q;
  assign outValid = out_valid_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: scoreboard bench for reg_dump_reader (default range, single-register range, optional checksum)
module tb_reg_dump_reader;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic        RST, start, outReady, start5, ready5;
  logic [4:0]  rdAddr, outIndex, rdAddr5, outIndex5;
  logic [63:0] rdData, outData, rdData5, outData5;
  logic        outValid, busy, done, outValid5, busy5, done5;
  logic [63:0] rf [32];
  assign rdData  = rf[rdAddr];
  assign rdData5 = rf[rdAddr5];
  typedef struct {
    logic [63:0] d;
    logic [4:0]  i;
    int          gap;
  } beat_t;
  beat_t q[$], q5[$], e, e5;
  int vecs = 0, errs = 0, cyc = 0, last_x = 0, done_cnt = 0, done5_cnt = 0, d0;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [63:0] csum, csum5, csum_c, rdData_c, outData_c;
  logic [4:0]  rdAddr_c, outIndex_c;
  logic        start_c, outValid_c, busy_c, done_c;
  logic [63:0] rfc [32];
  assign rdData_c = rfc[rdAddr_c];
  reg_dump_reader #(.FIRST_REG(0), .LAST_REG(1)) u_c (
    .CLK(CLK), .RST(RST), .start(start_c), .rdAddr(rdAddr_c), .rdData(rdData_c),
    .outData(outData_c), .outIndex(outIndex_c), .outValid(outValid_c), .outReady(ready5),
    .busy(busy_c), .done(done_c), .csum(csum_c));
`endif
  reg_dump_reader dut (
    .CLK(CLK), .RST(RST), .start(start), .rdAddr(rdAddr), .rdData(rdData),
    .outData(outData), .outIndex(outIndex), .outValid(outValid), .outReady(outReady),
    .busy(busy), .done(done)
`ifdef REG_DUMP_CHECKSUM_EN
    , .csum(csum)
`endif
  );
  reg_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) u5 (
    .CLK(CLK), .RST(RST), .start(start5), .rdAddr(rdAddr5), .rdData(rdData5),
    .outData(outData5), .outIndex(outIndex5), .outValid(outValid5), .outReady(ready5),
    .busy(busy5), .done(done5)
`ifdef REG_DUMP_CHECKSUM_EN
    , .csum(csum5)
`endif
  );
  // Transfers are judged at negedge: inputs only change just after posedge.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (done) done_cnt++;
    if (outValid && outReady && !RST) begin
      vecs++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL beat_extra: got idx %0d data %h, required none", outIndex, outData);
      end else begin
        e = q.pop_front();
        if (outData !== e.d || outIndex !== e.i) begin
          errs++;
          $display("FAIL beat: got idx %0d data %h, required idx %0d data %h", outIndex, outData, e.i, e.d);
        end else if (e.gap != 0 && cyc - last_x != e.gap) begin
          errs++;
          $display("FAIL beat_gap idx %0d: got %0d cycles, required %0d", outIndex, cyc - last_x, e.gap);
        end
      end
      last_x = cyc;
    end
  end
  always @(negedge CLK) begin
    if (done5) done5_cnt++;
    if (outValid5 && ready5 && !RST) begin
      vecs++;
      if (q5.size() == 0) begin
        errs++;
        $display("FAIL beat5_extra: got idx %0d data %h, required none", outIndex5, outData5);
      end else begin
        e5 = q5.pop_front();
        if (outData5 !== e5.d || outIndex5 !== e5.i) begin
          errs++;
          $display("FAIL beat5: got idx %0d data %h, required idx %0d data %h", outIndex5, outData5, e5.i, e5.d);
        end
      end
    end
  end
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    vecs++;
    if (a !== x) begin
      errs++;
      $display("FAIL %s: got %h, required %h", n, a, x);
    end
  endtask
  task automatic push(input int i, input int g);
    q.push_back('{(i == 31) ? 64'h0 : 64'(i) * 64'h1111, 5'(i), g});
  endtask
  task automatic wait_done(input string n);
    for (int k = 0; k < 400 && !done; k++) step;
    chk(n, {63'b0, done}, 64'd1);
  endtask
  task automatic wait_beat(input int b, input string n);
    for (int k = 0; k < 400 && !(outValid && outIndex == 5'(b)); k++) step;
    chk(n, {63'b0, outValid && outIndex == 5'(b)}, 64'd1);
  endtask
  initial begin
    RST = 1'b1; start = 1'b0; start5 = 1'b0; outReady = 1'b1; ready5 = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = (i == 31) ? 64'h0 : 64'(i) * 64'h1111;
`ifdef REG_DUMP_CHECKSUM_EN
    start_c = 1'b0;
    for (int i = 0; i < 32; i++) rfc[i] = 64'h0;
    rfc[0] = 64'hF0;
    rfc[1] = 64'h0F;
`endif
    repeat (3) step;
    chk("rst_valid", {63'b0, outValid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_data", outData, 64'd0);
    chk("rst_index", {59'b0, outIndex}, 64'd0);
    chk("rst_rdaddr5", {59'b0, rdAddr5}, 64'd5);
`ifdef REG_DUMP_CHECKSUM_EN
    chk("rst_csum", csum_c, 64'd0);
`endif
    RST = 1'b0;
    step;
    chk("rst_rdaddr", {59'b0, rdAddr}, 64'd0);
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) push(i, i == 0 ? 0 : 2);
    start = 1'b1; step; start = 1'b0;
    chk("busy_after_start", {63'b0, busy}, 64'd1);
    chk("valid_in_load", {63'b0, outValid}, 64'd0);
    step;
    chk("first_valid_latency", {63'b0, outValid}, 64'd1);
    chk("first_index", {59'b0, outIndex}, 64'd0);
    wait_done("dump1_done");
    chk("busy_at_done", {63'b0, busy}, 64'd0);
    step;
    chk("dump1_done_count", 64'(done_cnt - d0), 64'd1);
    chk("dump1_done_low", {63'b0, done}, 64'd0);
    chk("dump1_queue_empty", 64'(q.size()), 64'd0);
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) push(i, 0);
    start = 1'b1; step; start = 1'b0;
    wait_beat(3, "bp_reach_beat3");
    outReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step;
      chk("bp_data", outData, 64'h3333);
      chk("bp_index", {59'b0, outIndex}, 64'd3);
      chk("bp_valid", {63'b0, outValid}, 64'd1);
    end
    outReady = 1'b1;
    wait_beat(10, "reach_beat10");
    start = 1'b1; step; start = 1'b0;
    chk("busy_start_ignored", {63'b0, busy}, 64'd1);
    wait_done("dump2_done");
    step;
    chk("dump2_done_count", 64'(done_cnt - d0), 64'd1);
    chk("dump2_queue_empty", 64'(q.size()), 64'd0);
    repeat (4) step;
    chk("dump2_no_restart", {63'b0, busy}, 64'd0);
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) push(i, 0);
    start = 1'b1; step; start = 1'b0;
    wait_beat(7, "reach_beat7");
    RST = 1'b1; outReady = 1'b0;
    step;
    chk("abort_valid", {63'b0, outValid}, 64'd0);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_rdaddr", {59'b0, rdAddr}, 64'd0);
    RST = 1'b0; outReady = 1'b1;
    repeat (3) step;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_queue_empty", 64'(q.size()), 64'd0);
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) push(i, i == 0 ? 0 : 2);
    start = 1'b1; step; start = 1'b0;
    wait_done("dump4_done");
    step;
    chk("dump4_done_count", 64'(done_cnt - d0), 64'd1);
    chk("dump4_queue_empty", 64'(q.size()), 64'd0);
    d0 = done5_cnt;
    q5.push_back('{64'h5555, 5'd5, 0});
    start5 = 1'b1; step; start5 = 1'b0;
    for (int k = 0; k < 50 && !done5; k++) step;
    chk("single_done", {63'b0, done5}, 64'd1);
    step;
    chk("single_done_count", 64'(done5_cnt - d0), 64'd1);
    chk("single_queue_empty", 64'(q5.size()), 64'd0);
    chk("single_busy", {63'b0, busy5}, 64'd0);
`ifdef REG_DUMP_CHECKSUM_EN
    start_c = 1'b1; step; start_c = 1'b0;
    for (int k = 0; k < 50 && !done_c; k++) step;
    chk("csum_done", {63'b0, done_c}, 64'd1);
    chk("csum_at_done", csum_c, 64'hFF);
    repeat (3) step;
    chk("csum_stable", csum_c, 64'hFF);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
